// File: rtl/butterflyy.sv
// Three-stage pipelined FP16 radix-2 DIT butterfly: X = A + W*B, Y = A - W*B.
// Build option BFLY_SAT_EN: overflow saturates to max finite instead of signed Inf.
module butterflyy #(
  parameter int unsigned NBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] Ar,
  input  logic [NBITS-1:0] Ai,
  input  logic [NBITS-1:0] Br,
  input  logic [NBITS-1:0] Bi,
  input  logic [NBITS-1:0] Wr,
  input  logic [NBITS-1:0] Wi,
  output logic [NBITS-1:0] Xr_F,
  output logic [NBITS-1:0] Xi_F,
  output logic [NBITS-1:0] Yr_F,
  output logic [NBITS-1:0] Yi_F
);

  localparam logic [15:0] QNAN = 16'h7E00;

  function automatic logic [15:0] fp_ovf(input logic s);
`ifdef BFLY_SAT_EN
    return {s, 15'h7BFF};
`else
    return {s, 15'h7C00};
`endif
  endfunction

  // Truncating multiply; subnormal operands act as signed zero.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0]       prod;
    logic signed [6:0] e;
    logic [9:0]        m;
    logic              s;
    logic [15:0]       r;
    s    = a[15] ^ b[15];
    prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    e    = $signed({2'b00, a[14:10]}) + $signed({2'b00, b[14:10]}) - 7'sd15
           + (prod[21] ? 7'sd1 : 7'sd0);
    m    = prod[21] ? 10'(prod >> 11) : 10'(prod >> 10);
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) r = QNAN;
    else if (a[14:10] == 5'h00 || b[14:10] == 5'h00) r = {s, 15'h0000};
    else if (e > 7'sd30) r = fp_ovf(s);
    else if (e < 7'sd1) r = {s, 15'h0000};
    else r = {s, e[4:0], m};
    return r;
  endfunction

  // Truncating add; the smaller operand is aligned with guard/round/sticky bits.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       big, sml, r;
    logic [13:0]       mb, ms, al, diff, nrm;
    logic [44:0]       ext;
    logic [14:0]       sum;
    logic [4:0]        d;
    logic [3:0]        lz;
    logic              found;
    logic signed [6:0] e;
    r = 16'h0000;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d    = big[14:10] - sml[14:10];
    mb   = {1'b1, big[9:0], 3'b000};
    ms   = {1'b1, sml[9:0], 3'b000};
    ext  = {ms, 31'b0} >> d;
    al   = ext[44:31] | {13'b0, |ext[30:0]};
    sum  = {1'b0, mb} + {1'b0, al};
    diff = mb - al;
    lz    = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else lz = lz + 4'd1;
      end
    end
    nrm = diff << lz;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) r = QNAN;
    else if (a[14:10] == 5'h00 && b[14:10] == 5'h00) r = 16'h0000;
    else if (a[14:10] == 5'h00) r = b;
    else if (b[14:10] == 5'h00) r = a;
    else if (big[15] == sml[15]) begin
      e = $signed({2'b00, big[14:10]}) + (sum[14] ? 7'sd1 : 7'sd0);
      if (e > 7'sd30) r = fp_ovf(big[15]);
      else r = {big[15], e[4:0], sum[14] ? 10'(sum >> 4) : 10'(sum >> 3)};
    end else if (diff == 14'd0) begin
      r = 16'h0000;
    end else begin
      e = $signed({2'b00, big[14:10]}) - $signed({3'b000, lz});
      if (e < 7'sd1) r = {big[15], 15'h0000};
      else r = {big[15], e[4:0], 10'(nrm >> 3)};
    end
    return r;
  endfunction

  function automatic logic [15:0] fp_sub(input logic [15:0] a, input logic [15:0] b);
    return fp_add(a, {~b[15], b[14:0]});
  endfunction

  logic [NBITS-1:0] p0_q, p1_q, p2_q, p3_q, ar1_q, ai1_q;
  logic [NBITS-1:0] p0_d, p1_d, p2_d, p3_d, ar1_d, ai1_d;
  logic [NBITS-1:0] tr_q, ti_q, ar2_q, ai2_q;
  logic [NBITS-1:0] tr_d, ti_d, ar2_d, ai2_d;
  logic [NBITS-1:0] xr_q, xi_q, yr_q, yi_q;
  logic [NBITS-1:0] xr_d, xi_d, yr_d, yi_d;

  // Stage 1 products, stage 2 twiddled B, stage 3 butterfly sums.
  always_comb begin
    p0_d  = fp_mul(Br, Wr);
    p1_d  = fp_mul(Bi, Wi);
    p2_d  = fp_mul(Br, Wi);
    p3_d  = fp_mul(Bi, Wr);
    ar1_d = Ar;
    ai1_d = Ai;
    tr_d  = fp_sub(p0_q, p1_q);
    ti_d  = fp_add(p2_q, p3_q);
    ar2_d = ar1_q;
    ai2_d = ai1_q;
    xr_d  = fp_add(ar2_q, tr_q);
    xi_d  = fp_add(ai2_q, ti_q);
    yr_d  = fp_sub(ar2_q, tr_q);
    yi_d  = fp_sub(ai2_q, ti_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      p3_q  <= '0;
      ar1_q <= '0;
      ai1_q <= '0;
      tr_q  <= '0;
      ti_q  <= '0;
      ar2_q <= '0;
      ai2_q <= '0;
      xr_q  <= '0;
      xi_q  <= '0;
      yr_q  <= '0;
      yi_q  <= '0;
    end else begin
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      p3_q  <= p3_d;
      ar1_q <= ar1_d;
      ai1_q <= ai1_d;
      tr_q  <= tr_d;
      ti_q  <= ti_d;
      ar2_q <= ar2_d;
      ai2_q <= ai2_d;
      xr_q  <= xr_d;
      xi_q  <= xi_d;
      yr_q  <= yr_d;
      yi_q  <= yi_d;
    end
  end

  assign Xr_F = xr_q;
  assign Xi_F = xi_q;
  assign Yr_F = yr_q;
  assign Yi_F = yi_q;

endmodule

// File: tb/tb_butterflyy.sv
// Self-checking bench for butterflyy: directed spec vectors plus random vectors
// scored against a real-arithmetic FP16 reference model.
module tb_butterflyy;

  typedef struct packed {
    logic [15:0] ar, ai, br, bi, wr, wi;
  } vec_t;

  logic        clk, rst;
  logic [15:0] Ar, Ai, Br, Bi, Wr, Wi;
  logic [15:0] Xr_F, Xi_F, Yr_F, Yi_F;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] hist[$];
  logic [63:0] got, exp_out;

  butterflyy #(.NBITS(16)) dut (
    .clk(clk), .rst(rst),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi), .Wr(Wr), .Wi(Wi),
    .Xr_F(Xr_F), .Xi_F(Xi_F), .Yr_F(Yr_F), .Yi_F(Yi_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- reference model: exact real arithmetic, then truncate ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_val(input logic [15:0] x);
    real v;
    if (x[14:10] == 5'd0) return 0.0;
    v = real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] ovf_val(input logic s);
`ifdef BFLY_SAT_EN
    return {s, 15'h7BFF};
`else
    return {s, 15'h7C00};
`endif
  endfunction

  function automatic logic [15:0] fp_round(input real r);
    real  mag;
    int   e, mant;
    logic s;
    if (r == 0.0) return 16'h0000;
    s   = (r < 0.0);
    mag = s ? -r : r;
    e   = 0;
    while (pow2(e + 1) <= mag) e++;
    while (pow2(e) > mag) e--;
    if (e > 15) return ovf_val(s);
    if (e < -14) return {s, 15'h0000};
    mant = $rtoi(mag / pow2(e - 10));
    return {s, 5'(e + 15), 10'(mant - 1024)};
  endfunction

  function automatic logic is_special(input logic [15:0] x);
    return x[14:10] == 5'h1F;
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    if (is_special(a) || is_special(b)) return 16'h7E00;
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {a[15] ^ b[15], 15'h0000};
    return fp_round(fp_val(a) * fp_val(b));
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    if (is_special(a) || is_special(b)) return 16'h7E00;
    return fp_round(fp_val(a) + fp_val(b));
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] a, input logic [15:0] b);
    if (is_special(a) || is_special(b)) return 16'h7E00;
    return fp_round(fp_val(a) - fp_val(b));
  endfunction

  function automatic logic [63:0] bfly(input vec_t v);
    logic [15:0] tr, ti;
    tr = m_sub(m_mul(v.br, v.wr), m_mul(v.bi, v.wi));
    ti = m_add(m_mul(v.br, v.wi), m_mul(v.bi, v.wr));
    return {m_add(v.ar, tr), m_add(v.ai, ti), m_sub(v.ar, tr), m_sub(v.ai, ti)};
  endfunction

  // Apply one vector for one edge; the model pipeline tracks the 3-edge latency.
  task automatic step(input vec_t v, input logic r);
    {Ar, Ai, Br, Bi, Wr, Wi} = v;
    rst = r;
    @(posedge clk);
    if (!r) hist = '{64'h0, 64'h0, 64'h0};
    else begin
      hist.push_back(bfly(v));
      void'(hist.pop_front());
    end
    #1;
    exp_out = hist[0];
    got     = {Xr_F, Xi_F, Yr_F, Yi_F};
  endtask

  localparam vec_t V1   = {16'h4c00, 16'h0000, 16'h4c00, 16'h0000, 16'h3c00, 16'h0000};
  localparam vec_t V2   = {16'h4c00, 16'h0000, 16'h4c00, 16'h0000, 16'hbc00, 16'h0000};
  localparam vec_t V3   = {16'h4000, 16'h3c00, 16'h0000, 16'h3c00, 16'h0000, 16'h3c00};
  localparam vec_t V6   = {16'h7bff, 16'h0000, 16'h7bff, 16'h0000, 16'h3c00, 16'h0000};
  localparam vec_t VZ   = '0;
  localparam logic [63:0] R1 = 64'h5000_0000_0000_0000;
  localparam logic [63:0] R2 = 64'h0000_0000_5000_0000;
  localparam logic [63:0] R3 = 64'h3c00_3c00_4200_3c00;
`ifdef BFLY_SAT_EN
  localparam logic [63:0] R6 = 64'h7bff_0000_0000_0000;
`else
  localparam logic [63:0] R6 = 64'h7c00_0000_0000_0000;
`endif

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(V1, (i >= 2));
      n_checks++;
      if (got !== 64'h0) $display("FAIL reset_%0d: got %h required %h", i, got, 64'h0);
      else n_pass++;
    end
  endtask

  task automatic test_directed();
    vec_t        vs[3];
    logic [63:0] rs[3];
    vs = '{V1, V2, V3};
    rs = '{R1, R2, R3};
    for (int k = 0; k < 3; k++) begin
      step(vs[k], 1'b1);
      step(vs[k], 1'b1);
      step(vs[k], 1'b1);
      n_checks++;
      if (got !== rs[k]) $display("FAIL directed_%0d: got %h required %h", k + 1, got, rs[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    for (int j = 0; j < 10; j++) begin
      step((j >= 8) ? VZ : ((j % 2) != 0 ? V3 : V1), 1'b1);
      if (j >= 2) begin
        want = ((j - 2) % 2 != 0) ? R3 : R1;
        n_checks++;
        if (got !== want) $display("FAIL back_to_back_%0d: got %h required %h", j, got, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] want;
    step(V1, 1'b1);
    step(V3, 1'b1);
    step(V1, 1'b0);
    n_checks++;
    if (got !== 64'h0) $display("FAIL mid_reset_edge: got %h required %h", got, 64'h0);
    else n_pass++;
    for (int j = 0; j < 3; j++) begin
      step((j == 0) ? V3 : V1, 1'b1);
      want = (j == 2) ? R3 : 64'h0;
      n_checks++;
      if (got !== want) $display("FAIL mid_reset_resume_%0d: got %h required %h", j, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    step(V6, 1'b1);
    step(V6, 1'b1);
    step(V6, 1'b1);
    n_checks++;
    if (got !== R6) $display("FAIL overflow: got %h required %h", got, R6);
    else n_pass++;
  endtask

  function automatic logic [15:0] rnd_op();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 9))
        0: return 16'h3c00;
        1: return 16'hbc00;
        2: return 16'h4000;
        3: return 16'h4c00;
        4: return 16'h7bff;
        5: return 16'hfbff;
        6: return 16'h0001;
        7: return 16'h8000;
        8: return 16'h7c00;
        default: return 16'h7e01;
      endcase
    end
    return 16'($urandom);
  endfunction

  task automatic test_random();
    vec_t v;
    for (int j = 0; j < 400; j++) begin
      v = {rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      if ($urandom_range(0, 5) == 0) begin
        v.br = v.ar;
        v.bi = v.ai;
        v.wr = 16'h3c00;
        v.wi = 16'h0000;
      end
      step(v, 1'b1);
      n_checks++;
      if (got !== exp_out) $display("FAIL random_%0d: got %h required %h", j, got, exp_out);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    {Ar, Ai, Br, Bi, Wr, Wi} = '0;
    hist = '{64'h0, 64'h0, 64'h0};
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
